// File: rtl/program_run_checker_pkg.sv
// Shared types for the program run checker.
//   state_t     : run controller FSM states
//   exp_entry_t : one expectation-table record {valid, addr, data}
// EXP_DW / EXP_AW mirror the checker's DW / AW parameters; the top refuses
// to elaborate if they disagree.
package program_run_checker_pkg;

  localparam int EXP_DW = 8;
  localparam int EXP_AW = 8;

  typedef enum logic [2:0] {
    IDLE,
    HOLD_RST,
    RUN,
    CHECK,
    DONE
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [EXP_AW-1:0] addr;
    logic [EXP_DW-1:0] data;
  } exp_entry_t;

endpackage

// File: rtl/program_run_checker_table.sv
// Expectation table: NCHK-entry register file, one write port, one
// combinational read port, synchronous clear of the valid bits.
//   clk_i            : clock
//   clr_i            : synchronous clear of all valid bits
//   we_i             : write strobe (out-of-range widx_i is ignored)
//   widx_i           : write index
//   waddr_i, wdata_i : DM address / expected word to store
//   ridx_i           : read index
//   rentry_o         : entry at ridx_i (all zero when out of range)
module run_check_table
  import program_run_checker_pkg::*;
#(
  parameter int NCHK = 4,
  parameter int IW   = 2
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [IW-1:0]     widx_i,
  input  logic [EXP_AW-1:0] waddr_i,
  input  logic [EXP_DW-1:0] wdata_i,
  input  logic [IW-1:0]     ridx_i,
  output exp_entry_t        rentry_o
);

  exp_entry_t tbl_q [NCHK];

  // Only the valid bits are cleared; stale addr/data are never trusted
  // without a valid bit.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < NCHK; i++) begin
        tbl_q[i].valid <= 1'b0;
      end
    end else if (we_i && (32'(widx_i) < NCHK)) begin
      tbl_q[widx_i] <= '{valid: 1'b1, addr: waddr_i, data: wdata_i};
    end
  end

  assign rentry_o = (32'(ridx_i) < NCHK) ? tbl_q[ridx_i] : '0;

endmodule

// File: rtl/program_run_checker.sv
// Run controller for processor-level benches and bring-up: holds the DUT in
// reset for RST_CYCLES, lets it run under a TIMEOUT-cycle watchdog until
// dut_done, then walks the expectation table comparing DM words.
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin a run (accepted in IDLE/DONE)
//   exp_we/idx/addr/data: expectation table write (accepted when not busy)
//   dut_reset, dut_done : DUT reset drive, DUT completion flag
//   mem_addr, mem_rdata : DM read port tap (combinational read data)
//   busy, finished      : HOLD_RST/RUN/CHECK, DONE
//   pass, timed_out     : run verdict, valid when finished
//   fail_idx, fail_data : first mismatching entry and the word read there
//   cycle_count         : RUN cycles before done was sampled (or timeout)
module program_run_checker
  import program_run_checker_pkg::*;
#(
  parameter  int DW         = 8,
  parameter  int AW         = 8,
  parameter  int NCHK       = 4,
  parameter  int RST_CYCLES = 2,
  parameter  int TIMEOUT    = 1024,
  parameter  int CW         = 16,
  localparam int IW         = (NCHK > 1) ? $clog2(NCHK) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          exp_we,
  input  logic [IW-1:0] exp_idx,
  input  logic [AW-1:0] exp_addr,
  input  logic [DW-1:0] exp_data,
  output logic          dut_reset,
  input  logic          dut_done,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          finished,
  output logic          pass,
  output logic          timed_out,
  output logic [IW-1:0] fail_idx,
  output logic [DW-1:0] fail_data,
  output logic [CW-1:0] cycle_count
);

  localparam int             RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]  RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]  CYC_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NCHK - 1);

  if (TIMEOUT >= (1 << CW) || TIMEOUT < 1) begin : g_bad_timeout
    $error("program_run_checker: TIMEOUT must be in 1..2**CW-1");
  end
  if (NCHK < 1 || RST_CYCLES < 1) begin : g_bad_sizes
    $error("program_run_checker: NCHK and RST_CYCLES must be >= 1");
  end
  if (DW != EXP_DW || AW != EXP_AW) begin : g_bad_widths
    $error("program_run_checker: DW/AW must match package EXP_DW/EXP_AW");
  end

  state_t        state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          pass_q, pass_d;
  logic          to_q, to_d;
  logic [IW-1:0] fidx_q, fidx_d;
  logic [DW-1:0] fdata_q, fdata_d;

  exp_entry_t    rd_entry;
  logic          busy_w;
  logic          mismatch;

  assign busy_w   = (state_q == HOLD_RST) || (state_q == RUN) || (state_q == CHECK);
  assign mismatch = rd_entry.valid && (mem_rdata != rd_entry.data);

  run_check_table #(
    .NCHK (NCHK),
    .IW   (IW)
  ) u_table (
    .clk_i    (clk),
    .clr_i    (reset),
    .we_i     (exp_we && !busy_w),
    .widx_i   (exp_idx),
    .waddr_i  (exp_addr),
    .wdata_i  (exp_data),
    .ridx_i   (idx_q),
    .rentry_o (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rst_cnt_q <= '0;
      cyc_q     <= '0;
      idx_q     <= '0;
      pass_q    <= 1'b0;
      to_q      <= 1'b0;
      fidx_q    <= '0;
      fdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      cyc_q     <= cyc_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      to_q      <= to_d;
      fidx_q    <= fidx_d;
      fdata_q   <= fdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cyc_d     = cyc_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    to_d      = to_q;
    fidx_d    = fidx_q;
    fdata_d   = fdata_q;

    case (state_q)
      IDLE, DONE: begin
        // A new run wipes the previous verdict; the table is kept.
        if (start) begin
          state_d   = HOLD_RST;
          rst_cnt_d = '0;
          cyc_d     = '0;
          idx_d     = '0;
          pass_d    = 1'b0;
          to_d      = 1'b0;
          fidx_d    = '0;
          fdata_d   = '0;
        end
      end
      HOLD_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      RUN: begin
        // done is checked first so it wins over a same-cycle timeout; the
        // counter only advances on cycles that stay in RUN.
        if (dut_done) begin
          state_d = CHECK;
          idx_d   = '0;
        end else if (cyc_q == CYC_LAST) begin
          state_d = DONE;
          to_d    = 1'b1;
          pass_d  = 1'b0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      CHECK: begin
        if (mismatch) begin
          state_d = DONE;
          pass_d  = 1'b0;
          fidx_d  = idx_q;
          fdata_d = mem_rdata;
        end else if (idx_q == IDX_LAST) begin
          state_d = DONE;
          pass_d  = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dut_reset   = !((state_q == RUN) || (state_q == CHECK));
  assign busy        = busy_w;
  assign finished    = (state_q == DONE);
  assign mem_addr    = (state_q == CHECK) ? rd_entry.addr : '0;
  assign pass        = pass_q;
  assign timed_out   = to_q;
  assign fail_idx    = fidx_q;
  assign fail_data   = fdata_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_program_run_checker.sv
module tb_program_run_checker;

  localparam int DW = 8, AW = 8, NCHK = 3, RSTC = 2, TO = 16, CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          exp_we = 1'b0;
  logic [1:0]    exp_idx = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;
  logic          dut_reset;
  logic          dut_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          busy, finished, pass, timed_out;
  logic [1:0]    fail_idx;
  logic [DW-1:0] fail_data;
  logic [CW-1:0] cycle_count;

  always #5 clk = ~clk;

  program_run_checker #(
    .DW(DW), .AW(AW), .NCHK(NCHK), .RST_CYCLES(RSTC), .TIMEOUT(TO), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .exp_we(exp_we), .exp_idx(exp_idx),
    .exp_addr(exp_addr), .exp_data(exp_data), .dut_reset(dut_reset),
    .dut_done(dut_done), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy),
    .finished(finished), .pass(pass), .timed_out(timed_out), .fail_idx(fail_idx),
    .fail_data(fail_data), .cycle_count(cycle_count)
  );

  // Simple program model: raises done after done_after cycles out of reset.
  logic [DW-1:0] mem [256];
  int run_cnt = 0;
  int done_after = 1000;
  assign mem_rdata = mem[mem_addr];
  assign dut_done  = (run_cnt >= done_after);
  always @(posedge clk) begin
    if (dut_reset) run_cnt <= 0;
    else           run_cnt <= run_cnt + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; exp_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load(input int idx, input int a, input int d);
    @(negedge clk);
    exp_we = 1'b1; exp_idx = 2'(idx); exp_addr = 8'(a); exp_data = 8'(d);
    @(negedge clk);
    exp_we = 1'b0;
  endtask

  // Starts a run and follows it to finished. Iteration 0 is the first
  // HOLD_RST cycle. At iteration 'poke' start and exp_we are pulsed.
  task automatic do_run(input int poke, output int hold, output int t_done,
                        output int t_fin, output bit saw, output int h_fidx,
                        output int h_fdata);
    hold = 0; t_done = -1; t_fin = -1; saw = 1'b0; h_fidx = -1; h_fdata = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i == 0) begin h_fidx = int'(fail_idx); h_fdata = int'(fail_data); end
      if (busy && dut_reset) hold++;
      if (mem_addr != '0) saw = 1'b1;
      if (t_done < 0 && dut_done && !dut_reset) t_done = i;
      if (finished) begin t_fin = i; break; end
      if (i == poke) begin
        start = 1'b1; exp_we = 1'b1; exp_idx = 2'd0; exp_addr = 8'h06; exp_data = 8'h66;
      end else begin
        start = 1'b0; exp_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; exp_we = 1'b0;
  endtask

  typedef struct {
    int done_after;
    int m0, m1, m2;
    int e_pass, e_to, e_fidx, e_fdata, e_cyc, e_tfin;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int hold, t_done, t_fin, h_fidx, h_fdata;
    bit saw;

    // entries {0x10:7},{0x11:3},{0x12:9}
    vecs[0] = '{10,  7, 3, 9, 1, 0, 0, 0, 10, 16};
    vecs[1] = '{4,   7, 3, 8, 0, 0, 2, 8, 4,  10};
    vecs[2] = '{1,   5, 3, 9, 0, 0, 0, 5, 1,  5};
    vecs[3] = '{0,   7, 4, 8, 0, 0, 1, 4, 0,  5};
    vecs[4] = '{999, 7, 3, 9, 0, 1, 0, 0, 15, 18};

    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    do_reset();
    chk("rst_dut_reset", int'(dut_reset), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_finished", int'(finished), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_timed_out", int'(timed_out), 0);
    chk("rst_fail_idx", int'(fail_idx), 0);
    chk("rst_fail_data", int'(fail_data), 0);
    chk("rst_cycle_count", int'(cycle_count), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);

    // Adder program
    load(0, 0, 7);
    mem[0] = 8'd7;
    done_after = 10;
    do_run(-1, hold, t_done, t_fin, saw, h_fidx, h_fdata);
    chk("add_hold", hold, RSTC);
    chk("add_tdone", t_done, 12);
    chk("add_latency", t_fin - t_done, NCHK + 1);
    chk("add_pass", int'(pass), 1);
    chk("add_timed_out", int'(timed_out), 0);
    chk("add_cycles", int'(cycle_count), 10);
    chk("add_dut_reset_done", int'(dut_reset), 1);
    chk("add_busy_done", int'(busy), 0);

    // Ignored inputs: out-of-range index in DONE, start/exp_we during RUN
    load(3, 5, 8'h55);
    mem[5] = 8'h00; mem[6] = 8'h00;
    done_after = 8;
    do_run(4, hold, t_done, t_fin, saw, h_fidx, h_fdata);
    chk("ign_hold", hold, RSTC);
    chk("ign_tfin", t_fin, 14);
    chk("ign_pass", int'(pass), 1);
    chk("ign_cycles", int'(cycle_count), 8);

    // Table-driven runs
    load(0, 8'h10, 7);
    load(1, 8'h11, 3);
    load(2, 8'h12, 9);
    for (int v = 0; v < 5; v++) begin
      mem[8'h10] = 8'(vecs[v].m0);
      mem[8'h11] = 8'(vecs[v].m1);
      mem[8'h12] = 8'(vecs[v].m2);
      done_after = vecs[v].done_after;
      do_run(-1, hold, t_done, t_fin, saw, h_fidx, h_fdata);
      chk($sformatf("v%0d_hold", v), hold, RSTC);
      chk($sformatf("v%0d_tfin", v), t_fin, vecs[v].e_tfin);
      chk($sformatf("v%0d_pass", v), int'(pass), vecs[v].e_pass);
      chk($sformatf("v%0d_timed_out", v), int'(timed_out), vecs[v].e_to);
      chk($sformatf("v%0d_fail_idx", v), int'(fail_idx), vecs[v].e_fidx);
      chk($sformatf("v%0d_fail_data", v), int'(fail_data), vecs[v].e_fdata);
      chk($sformatf("v%0d_cycles", v), int'(cycle_count), vecs[v].e_cyc);
      chk($sformatf("v%0d_check_entered", v), int'(saw), 1 - vecs[v].e_to);
    end

    // Mismatch at entry 2, then rerun from DONE after fixing memory
    load(0, 0, 7);
    load(1, 1, 3);
    load(2, 2, 9);
    mem[0] = 8'd7; mem[1] = 8'd3; mem[2] = 8'd8;
    done_after = 5;
    do_run(-1, hold, t_done, t_fin, saw, h_fidx, h_fdata);
    chk("mm_pass", int'(pass), 0);
    chk("mm_fail_idx", int'(fail_idx), 2);
    chk("mm_fail_data", int'(fail_data), 8);
    mem[2] = 8'd9;
    do_run(-1, hold, t_done, t_fin, saw, h_fidx, h_fdata);
    chk("rerun_hold", hold, RSTC);
    chk("rerun_cleared_fidx", h_fidx, 0);
    chk("rerun_cleared_fdata", h_fdata, 0);
    chk("rerun_pass", int'(pass), 1);
    chk("rerun_fail_idx", int'(fail_idx), 0);

    // Reset in the middle of RUN
    load(0, 7, 8'h77);
    mem[7] = 8'h00;
    done_after = 50;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    chk("mid_dut_reset", int'(dut_reset), 0);
    chk("mid_cycles", int'(cycle_count), 4);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_dut_reset", int'(dut_reset), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_finished", int'(finished), 0);
    chk("abort_cycles", int'(cycle_count), 0);
    chk("abort_mem_addr", int'(mem_addr), 0);
    reset = 1'b0;
    done_after = 3;
    do_run(-1, hold, t_done, t_fin, saw, h_fidx, h_fdata);
    chk("vac_tfin", t_fin, 9);
    chk("vac_pass", int'(pass), 1);
    chk("vac_timed_out", int'(timed_out), 0);
    chk("vac_cycles", int'(cycle_count), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
